// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: multi-cycle data-memory access controller for the M stage.
// Takes one load/store at a time and drives a request/ready memory port. It
// builds store byte enables and replicated write data and extends load data.
// It stalls the pipeline until the access completes and flags address errors,
// including an access that times out waiting for the memory.
module dm_access_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [4:0]  exc_code,
  output logic        m_data_req,
  output logic [31:0] m_data_addr,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_wdata,
  input  logic [31:0] m_data_rdata,
  input  logic        m_data_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_BU = 3'b010;
  localparam logic [2:0] OP_H  = 3'b011;
  localparam logic [2:0] OP_HU = 3'b100;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q;
  logic [2:0]  op_q;
  logic        we_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] addr_q;
  logic [3:0]  byteen_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [4:0]  exc_q;

  logic        req_legal;
  logic [3:0]  st_byteen;
  logic [31:0] st_wdata;
  logic        accept;
  logic        reject;
  logic        complete;
  logic        timeout;

  // Selects the addressed byte/half of a memory word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      OP_B:    res = {{24{b[7]}}, b};
      OP_BU:   res = {24'h0, b};
      OP_H:    res = {{16{h[15]}}, h};
      OP_HU:   res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Request legality plus store byte enables and replicated write data.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_legal = 1'b0;
    st_byteen = 4'b0000;
    st_wdata  = 32'h0;
    case (req_op)
      OP_W: begin
        req_legal = (req_addr[1:0] == 2'b00);
        st_byteen = 4'b1111;
        st_wdata  = req_wdata;
      end
      OP_B, OP_BU: begin
        req_legal = !(req_we && (req_op == OP_BU));
        st_byteen = 4'b0001 << req_addr[1:0];
        st_wdata  = {4{req_wdata[7:0]}};
      end
      OP_H, OP_HU: begin
        req_legal = !req_addr[0] && !(req_we && (req_op == OP_HU));
        st_byteen = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata  = {2{req_wdata[15:0]}};
      end
      default: req_legal = 1'b0;
    endcase
  end

  // Next-state logic; ready beats timeout when both land in the same cycle.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    reject   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            accept  = 1'b1;
            state_d = S_WAIT;
          end else begin
            reject  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (m_data_ready) begin
          complete = 1'b1;
          state_d  = S_DONE;
        end else if (wait_cnt_q == MAX_WAIT_C) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Transaction registers: captured at accept, result captured at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
      op_q       <= OP_W;
      we_q       <= 1'b0;
      addr_lo_q  <= 2'b00;
      addr_q     <= 32'h0;
      byteen_q   <= 4'b0000;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      exc_q      <= EXC_NONE;
    end else begin
      if (accept) begin
        wait_cnt_q <= 8'd0;
        op_q       <= req_op;
        we_q       <= req_we;
        addr_lo_q  <= req_addr[1:0];
        addr_q     <= {req_addr[31:2], 2'b00};
        byteen_q   <= req_we ? st_byteen : 4'b0000;
        wdata_q    <= req_we ? st_wdata : 32'h0;
      end
      if ((state_q == S_WAIT) && !m_data_ready && (wait_cnt_q != MAX_WAIT_C))
        wait_cnt_q <= wait_cnt_q + 8'd1;
      if (complete) begin
        rdata_q <= we_q ? 32'h0 : load_extend(op_q, addr_lo_q, m_data_rdata);
        exc_q   <= EXC_NONE;
      end
      if (reject) begin
        rdata_q <= 32'h0;
        exc_q   <= req_we ? EXC_ADES : EXC_ADEL;
      end
      if (timeout) begin
        rdata_q <= 32'h0;
        exc_q   <= we_q ? EXC_ADES : EXC_ADEL;
      end
    end
  end

  assign stall         = req_valid && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign rdata         = rdata_q;
  assign exc_code      = exc_q;
  assign m_data_req    = (state_q == S_WAIT);
  assign m_data_addr   = addr_q;
  assign m_data_byteen = byteen_q;
  assign m_data_wdata  = wdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: scoreboard bench for dm_access_ctrl. Expected results are
// queued when a request is driven and compared when done pulses.
module tb_dm_access_ctrl;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic [4:0]  exc_code;
  logic        m_data_req;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic [31:0] m_data_rdata;
  logic        m_data_ready;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic [4:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  dm_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .done          (done),
    .rdata         (rdata),
    .exc_code      (exc_code),
    .m_data_req    (m_data_req),
    .m_data_addr   (m_data_addr),
    .m_data_byteen (m_data_byteen),
    .m_data_wdata  (m_data_wdata),
    .m_data_rdata  (m_data_rdata),
    .m_data_ready  (m_data_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_exc", {27'h0, exc_code}, {27'h0, e.exc});
        if (!e.we) check("sb_rdata", rdata, e.rdata);
      end
    end
  end

  // Drives one request starting just after a rising edge and follows it to done.
  // ready_at: WAIT-cycle index at which m_data_ready is raised (-1 = never).
  task automatic access(input string tag, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mem_word, input int ready_at,
                        input logic ready_in_idle, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic [4:0] exp_exc,
                        input logic legal, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    int lat;
    req_valid    = 1'b1;
    req_we       = we;
    req_op       = op;
    req_addr     = addr;
    req_wdata    = wdata;
    m_data_rdata = mem_word;
    m_data_ready = ready_in_idle;
    sb_q.push_back('{we: we, rdata: exp_rdata, exc: exp_exc});
    @(negedge clk);
    check({tag, "_stall_at_accept"}, {31'h0, stall}, 32'd1);
    check({tag, "_no_req_at_accept"}, {31'h0, m_data_req}, 32'd0);
    check({tag, "_no_done_at_accept"}, {31'h0, done}, 32'd0);
    lat = 0;
    for (int k = 0; k < int'(MAX_WAIT) + 4; k++) begin
      @(posedge clk);
      #1;
      lat++;
      m_data_ready = (k == ready_at);
      @(negedge clk);
      if (done) break;
      if (legal) begin
        check({tag, "_req"}, {31'h0, m_data_req}, 32'd1);
        check({tag, "_addr"}, m_data_addr, {addr[31:2], 2'b00});
        check({tag, "_byteen"}, {28'h0, m_data_byteen}, {28'h0, exp_be});
        if (we) check({tag, "_wdata"}, m_data_wdata, exp_wd);
      end else begin
        check({tag, "_illegal_no_req"}, {31'h0, m_data_req}, 32'd0);
      end
      check({tag, "_stall_wait"}, {31'h0, stall}, 32'd1);
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_done"}, {31'h0, stall}, 32'd0);
    check({tag, "_req_done"}, {31'h0, m_data_req}, 32'd0);
  endtask

  // Drops the request for one cycle and confirms the controller is idle.
  task automatic idle_cycle(input string tag);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    m_data_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_done"}, {31'h0, done}, 32'd0);
    check({tag, "_idle_req"}, {31'h0, m_data_req}, 32'd0);
    check({tag, "_idle_stall"}, {31'h0, stall}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_op       = 3'b000;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    m_data_rdata = 32'h0;
    m_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_exc", {27'h0, exc_code}, 32'h0);
    check("rst_req", {31'h0, m_data_req}, 32'd0);
    check("rst_byteen", {28'h0, m_data_byteen}, 32'h0);
    check("rst_addr", m_data_addr, 32'h0);
    check("rst_wdata", m_data_wdata, 32'h0);
    check("rst_stall_low", {31'h0, stall}, 32'd0);
    req_valid = 1'b1;
    #1;
    check("rst_stall_follows_valid", {31'h0, stall}, 32'd1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    // lb at 0x13, byte 3 = 0x80 sign-extended
    access("lb", 1'b0, 3'b001, 32'h0000_0013, 32'h0, 32'h80FF_1234, 0, 1'b0, 2,
           32'hFFFF_FF80, 5'd0, 1'b1, 4'b0000, 32'h0);
    idle_cycle("lb");

    // sh at 0x22, ready on the 4th WAIT cycle
    access("sh", 1'b1, 3'b011, 32'h0000_0022, 32'hAAAA_BEEF, 32'h0, 3, 1'b0, 5,
           32'h0, 5'd0, 1'b1, 4'b1100, 32'hBEEF_BEEF);
    idle_cycle("sh");

    // sb at 0x101, lane 1
    access("sb", 1'b1, 3'b001, 32'h0000_0101, 32'h1234_565A, 32'h0, 1, 1'b0, 3,
           32'h0, 5'd0, 1'b1, 4'b0010, 32'h5A5A_5A5A);
    idle_cycle("sb");

    // sw at 0x20
    access("sw", 1'b1, 3'b000, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 0, 1'b0, 2,
           32'h0, 5'd0, 1'b1, 4'b1111, 32'hCAFE_F00D);
    idle_cycle("sw");

    // lh at 0x02, upper half 0x8001 sign-extended
    access("lh", 1'b0, 3'b011, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 1'b0, 2,
           32'hFFFF_8001, 5'd0, 1'b1, 4'b0000, 32'h0);
    idle_cycle("lh");

    // lbu at 0x11, byte 1 = 0xF0 zero-extended
    access("lbu", 1'b0, 3'b010, 32'h0000_0011, 32'h0, 32'h0000_F000, 0, 1'b0, 2,
           32'h0000_00F0, 5'd0, 1'b1, 4'b0000, 32'h0);
    idle_cycle("lbu");

    // misaligned lw and sw, illegal op codes
    access("lw_mis", 1'b0, 3'b000, 32'h0000_0006, 32'h0, 32'h1111_1111, 0, 1'b0, 1,
           32'h0, 5'd4, 1'b0, 4'b0000, 32'h0);
    idle_cycle("lw_mis");
    access("sw_mis", 1'b1, 3'b000, 32'h0000_0005, 32'h0, 32'h0, 0, 1'b0, 1,
           32'h0, 5'd5, 1'b0, 4'b0000, 32'h0);
    idle_cycle("sw_mis");
    access("sh_mis", 1'b1, 3'b011, 32'h0000_0021, 32'h0, 32'h0, 0, 1'b0, 1,
           32'h0, 5'd5, 1'b0, 4'b0000, 32'h0);
    idle_cycle("sh_mis");
    access("op101", 1'b0, 3'b101, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b0, 1,
           32'h0, 5'd4, 1'b0, 4'b0000, 32'h0);
    idle_cycle("op101");
    access("sbu_st", 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 0, 1'b0, 1,
           32'h0, 5'd5, 1'b0, 4'b0000, 32'h0);
    idle_cycle("sbu_st");

    // timeout: lhu with no ready, done at T+MAX_WAIT+2
    access("lhu_to", 1'b0, 3'b100, 32'h0000_0040, 32'h0, 32'hFFFF_FFFF, -1, 1'b0,
           int'(MAX_WAIT) + 2, 32'h0, 5'd4, 1'b1, 4'b0000, 32'h0);
    idle_cycle("lhu_to");
    access("lhu", 1'b0, 3'b100, 32'h0000_0042, 32'h0, 32'h8001_0000, 0, 1'b0, 2,
           32'h0000_8001, 5'd0, 1'b1, 4'b0000, 32'h0);
    idle_cycle("lhu");

    // timeout on a store reports AdES
    access("sw_to", 1'b1, 3'b000, 32'h0000_0080, 32'h5555_AAAA, 32'h0, -1, 1'b0,
           int'(MAX_WAIT) + 2, 32'h0, 5'd5, 1'b1, 4'b1111, 32'h5555_AAAA);
    idle_cycle("sw_to");

    // ready on the last allowed WAIT cycle wins over timeout
    access("lw_late", 1'b0, 3'b000, 32'h0000_0104, 32'h0, 32'h1357_9BDF,
           int'(MAX_WAIT), 1'b0, int'(MAX_WAIT) + 2, 32'h1357_9BDF, 5'd0, 1'b1,
           4'b0000, 32'h0);
    idle_cycle("lw_late");

    // reset in WAIT: no done, controller idle on the next cycle
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_op       = 3'b000;
    req_addr     = 32'h0000_0030;
    req_wdata    = 32'h1234_5678;
    m_data_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rstw_req_t1", {31'h0, m_data_req}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rstw_stall_t2", {31'h0, stall}, 32'd1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rstw_req_t3", {31'h0, m_data_req}, 32'd0);
    check("rstw_stall_t3", {31'h0, stall}, 32'd0);
    check("rstw_done_t3", {31'h0, done}, 32'd0);
    check("rstw_exc_t3", {27'h0, exc_code}, 32'h0);
    @(posedge clk);
    #1;
    access("lw_after_rst", 1'b0, 3'b000, 32'h0000_0030, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 2,
           32'h0BAD_F00D, 5'd0, 1'b1, 4'b0000, 32'h0);

    // back-to-back with req_valid held; ready raised during IDLE must be ignored
    @(posedge clk);
    #1;
    access("b2b_1", 1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h2468_ACE0, 1, 1'b0, 3,
           32'h2468_ACE0, 5'd0, 1'b1, 4'b0000, 32'h0);
    @(posedge clk);
    #1;
    access("b2b_2", 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h007F_0000, 1, 1'b1, 3,
           32'h0000_007F, 5'd0, 1'b1, 4'b0000, 32'h0);
    idle_cycle("b2b");

    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Multi-cycle data-memory access controller for the M stage. It accepts one load/store request at a time from the pipeline and drives a variable-latency data-memory port with a request/ready handshake. It generates store byte enables and replicated write data, and sign/zero-extends load data. It stalls the pipeline until the access completes and reports address-error exceptions, including on timeout.

## Interface
Parameters:
- MAX_WAIT, 15: maximum WAIT cycles without m_data_ready before the access is aborted as a bus error (1..255).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  M stage holds a memory instruction.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  access width code:
  - 000 word
  - 001 byte signed
  - 010 byte unsigned
  - 011 half signed
  - 100 half unsigned
  - stores use only 000, 001 and 011.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half/word is used.
- stall  out  1  hold the pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data; valid while done=1.
- exc_code  out  5  0 = none, 4 = AdEL, 5 = AdES; valid while done=1.
- m_data_req  out  1  memory request, held until ready.
- m_data_addr  out  32  word-aligned address: {req_addr[31:2],2'b00}.
- m_data_byteen  out  4  store byte enables; 0000 for loads.
- m_data_wdata  out  32  replicated store data.
- m_data_rdata  in  32  memory read word.
- m_data_ready  in  1  memory completes the access this cycle.

## Operation
- States: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, req_valid=1, request legal:
  - Register addr, byteen, wdata, op and we.
  - Go to WAIT.
- IDLE, req_valid=1, request illegal:
  - Illegal means a misaligned word (addr[1:0]≠0), a misaligned half (addr[0]≠0), or an op code of 101..111 (or 010/100 with we=1).
  - Go to DONE with exc_code = 4 for a load, 5 for a store. rdata = 0.
  - m_data_req is never asserted for an illegal request.
- WAIT:
  - m_data_req=1 with registered address, byteen and wdata held stable.
  - On m_data_ready=1: capture the extended load data and go to DONE with exc_code=0.
  - Wait counter increments each WAIT cycle without ready.
  - When the counter reaches MAX_WAIT with no ready: go to DONE with exc_code 4/5, rdata=0.
- DONE: done=1 for one cycle, then IDLE. A new request is accepted no earlier than the cycle after DONE.
- Once accepted, a transaction always completes; dropping req_valid does not abort it.
- Store byte enables:
  - sw: 1111
  - sh: addr[1] ? 1100 : 0011
  - sb: 0001 << addr[1:0]
- Store write data:
  - sw: wdata
  - sh: {wdata[15:0], wdata[15:0]}
  - sb: {4{wdata[7:0]}}
- Load extension:
  - Half selected by addr[1]; byte selected by addr[1:0].
  - Signed ops replicate the selected MSB into the upper bits; unsigned ops fill the upper bits with 0.
  - Word loads pass the word through unchanged.
- stall = req_valid & (state≠DONE). A request in IDLE stalls in its own cycle.

## Timing
- Reset values:
  - state IDLE, counter 0
  - stall 0 (it follows req_valid combinationally), done 0, rdata 0, exc_code 0
  - m_data_req 0, m_data_byteen 0, m_data_addr 0, m_data_wdata 0
- Best-case latency: accept at cycle T, ready at T+1, done at T+2. The pipeline advances at the T+2 edge.
- Illegal request: accepted at T, done with exception at T+1; no memory traffic.
- Timeout: done at T+1+MAX_WAIT+1.
- Ready and timeout in the same cycle: ready wins, no exception.
- Ready sampled while in IDLE or DONE is ignored.
- Reset asserted in WAIT or DONE: IDLE and m_data_req=0 from the next cycle; no done pulse.

## Test plan
- Byte load: lb at addr 0x0000_0013, m_data_rdata=0x80FF_1234, ready at T+1 -> done at T+2, rdata=0xFFFF_FF80, exc_code=0, m_data_byteen=0000, m_data_addr=0x10.
- Half store: sh at 0x22, wdata=0xAAAA_BEEF, ready after 3 WAIT cycles -> m_data_byteen=1100, m_data_wdata=0xBEEF_BEEF held stable all 3 cycles, done at T+5, stall high until then.
- Misaligned word load: lw at 0x0000_0006 -> no m_data_req, done at T+1, exc_code=4; sw at 0x5 -> exc_code=5.
- Timeout: lhu at 0x40, MAX_WAIT=15, ready never -> done at T+17 with exc_code=4, m_data_req low after; then an lhu with rdata=0x8001_0000 at addr 0x42 -> rdata=0x0000_8001.
- Reset mid-WAIT: sw accepted, reset at T+2 -> m_data_req=0 and stall=req_valid at T+3, no done; next request accepted normally.
- Back-to-back: two loads with req_valid held -> second accepted the cycle after the first done; ready asserted during IDLE is ignored.
